// File: rtl/shifter.sv
// Key-stream generator: rotates a seeded message-sized state left by SHIFT_AMT
// per enabled clock. Optional macro SHIFTER_XOR_MIX_EN mixes the state into out.
`ifndef MSG_SIZE
`define MSG_SIZE 240
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 240
`endif

module shifter #(
  parameter int unsigned MSG_SIZE  = `MSG_SIZE,
  parameter int unsigned KEY_SIZE  = `KEY_SIZE,
  parameter int unsigned SHIFT_AMT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [MSG_SIZE-1:0] initial_msg,
  output logic [KEY_SIZE-1:0] out,
  output logic                wrap
);

  localparam int unsigned CNT_W = $clog2(MSG_SIZE) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [MSG_SIZE-1:0] st;
  logic [CNT_W-1:0]    cnt;
  logic [MSG_SIZE-1:0] rot_c;
  logic [SUM_W-1:0]    sum_c;
  logic                done_c;
  logic [MSG_SIZE-1:0] src_c;

  assign rot_c  = {st[MSG_SIZE-1-SHIFT_AMT:0], st[MSG_SIZE-1:MSG_SIZE-SHIFT_AMT]};
  assign sum_c  = {1'b0, cnt} + SUM_W'(SHIFT_AMT);
  assign done_c = (sum_c >= SUM_W'(MSG_SIZE));

  // Reset and enable=0 both reload the seed; reset therefore dominates enable.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      st   <= initial_msg;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      st <= rot_c;
      if (done_c) begin
        cnt  <= CNT_W'(sum_c - SUM_W'(MSG_SIZE));
        wrap <= 1'b1;
      end else begin
        cnt  <= CNT_W'(sum_c);
        wrap <= 1'b0;
      end
    end
  end

`ifdef SHIFTER_XOR_MIX_EN
  assign src_c = st ^ {st[0], st[MSG_SIZE-1:1]};
`else
  assign src_c = st;
`endif

  // Narrow keys take the LSBs; wide keys repeat the state and truncate.
  generate
    if (KEY_SIZE <= MSG_SIZE) begin : g_narrow
      assign out = src_c[KEY_SIZE-1:0];
    end else begin : g_wide
      logic [2*MSG_SIZE-1:0] dbl_c;
      assign dbl_c = {src_c, src_c};
      assign out   = dbl_c[KEY_SIZE-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: driver queues expected out/wrap per edge,
// a negedge monitor pops and compares.
module tb_shifter;

  localparam int unsigned M = 240;
  localparam int unsigned K = 240;

  localparam logic [M-1:0] SEED =
    240'hABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF012345;
  localparam logic [M-1:0] ROT1 =
    240'hCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF012345AB;
  localparam logic [M-1:0] ALT =
    240'h5555AAAA5555AAAA5555AAAA5555AAAA5555AAAA5555AAAA5555AAAA5555;

  typedef struct {
    logic [K-1:0] o;
    logic         w;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [M-1:0] initial_msg;
  logic [K-1:0] out;
  logic         wrap;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [M-1:0] seed_m;
  int           k_m;

  shifter dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .initial_msg (initial_msg),
    .out         (out),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] rotl(input logic [M-1:0] s, input int n);
    return (s << n) | (s >> (M - n));
  endfunction

  function automatic logic [K-1:0] key_of(input logic [M-1:0] s);
    logic [M-1:0]   x;
    logic [2*M-1:0] d;
    x = s;
`ifdef SHIFTER_XOR_MIX_EN
    x = s ^ {s[0], s[M-1:1]};
`endif
    d = {x, x};
    return d[K-1:0];
  endfunction

  // Apply one edge; expected value is hand-given when use_hand, else from the rotation model.
  task automatic step(input logic r, input logic e, input logic [M-1:0] m,
                      input bit use_hand, input logic [K-1:0] hand, input string name);
    exp_t it;
    reset = r; enable = e; initial_msg = m;
    @(posedge clk);
    if (r || !e) begin
      seed_m = m;
      k_m    = 0;
    end else begin
      k_m = k_m + 1;
    end
    #1;
    it.o    = use_hand ? hand : key_of(rotl(seed_m, (8 * k_m) % M));
    it.w    = (!r && e && k_m > 0 && (k_m % 30) == 0);
    it.name = name;
    q.push_back(it);
  endtask

  task automatic run_en(input int n, input logic [M-1:0] m, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, m, 1'b0, '0, name);
  endtask

  // Monitor: out/wrap presented every cycle after an edge the driver accounted for.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        n_checks++;
        if (out !== it.o) begin
          n_fail++;
          $display("FAIL %s out: got %h want %h", it.name, out, it.o);
        end
        n_checks++;
        if (wrap !== it.w) begin
          n_fail++;
          $display("FAIL %s wrap: got %b want %b", it.name, wrap, it.w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] one;
    logic [K-1:0] one_exp;
    reset = 1'b0; enable = 1'b0; initial_msg = '0;
    seed_m = '0; k_m = 0;
    @(negedge clk);

    // Reset load and single rotate (hand values).
    step(1'b1, 1'b0, SEED, 1'b1, key_of(SEED), "reset_load");
    step(1'b0, 1'b1, ALT, 1'b1, key_of(ROT1), "single_rotate");
    // Full rotation with initial_msg changing underneath; seed must reappear on the 30th.
    run_en(28, ALT, "full_rot");
    step(1'b0, 1'b1, ALT, 1'b1, key_of(SEED), "full_rot_30");
    step(1'b0, 1'b1, SEED, 1'b1, key_of(ROT1), "full_rot_31");

    // Enable drop mid-rotation reloads the seed and restarts the count.
    run_en(4, SEED, "pre_drop");
    step(1'b0, 1'b0, SEED, 1'b1, key_of(SEED), "enable_drop");
    run_en(29, SEED, "after_drop");
    step(1'b0, 1'b1, SEED, 1'b1, key_of(SEED), "after_drop_30");
    run_en(1, SEED, "after_drop_31");

    // Reset wins over enable after partial rotation.
    step(1'b0, 1'b0, SEED, 1'b0, '0, "reload");
    run_en(3, SEED, "pre_prio");
    step(1'b1, 1'b1, SEED, 1'b1, key_of(SEED), "reset_prio");
    step(1'b0, 1'b1, SEED, 1'b1, key_of(ROT1), "prio_rot1");
    run_en(28, SEED, "prio_cnt");
    step(1'b0, 1'b1, SEED, 1'b1, key_of(SEED), "prio_wrap_30");

    // Reset right after a wrap clears it; single-bit seed exercises the mix path.
    one = '0; one[0] = 1'b1;
    one_exp = '0;
`ifdef SHIFTER_XOR_MIX_EN
    one_exp[M-1] = 1'b1;
`endif
    one_exp[0] = 1'b1;
    step(1'b1, 1'b0, one, 1'b1, one_exp, "one_hot_seed");
    step(1'b0, 1'b1, one, 1'b0, '0, "one_hot_rot");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
